// File: rtl/occupancy_arbiter_if.sv
// Handshake and status bundle between the increment/decrement requesters
// and the occupancy arbiter.
interface occupancy_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             inc_req;
  logic             dec_req;
  logic             inc_ack;
  logic             inc_nack;
  logic             dec_ack;
  logic             dec_nack;
  logic [WIDTH-1:0] count;
  logic             full;
  logic             empty;
  logic             busy;

  modport master (
    output inc_req, dec_req,
    input  inc_ack, inc_nack, dec_ack, dec_nack, count, full, empty, busy
  );

  modport slave (
    input  inc_req, dec_req,
    output inc_ack, inc_nack, dec_ack, dec_nack, count, full, empty, busy
  );
endinterface

// File: rtl/occupancy_arbiter.sv
// Saturating up/down occupancy counter shared by two four-phase req/ack
// requesters, with round-robin resolution of simultaneous requests.
module occupancy_arbiter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input logic           clk,
  input logic           rst,
  occupancy_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RELEASE} state_t;
  typedef enum logic {SEL_INC, SEL_DEC} sel_t;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  state_t           r_state;
  sel_t             r_sel;
  sel_t             r_last_served;
  logic [WIDTH-1:0] r_count;
  logic             r_inc_ack;
  logic             r_inc_nack;
  logic             r_dec_ack;
  logic             r_dec_nack;
  logic             r_busy;
  logic             w_sel_req;

  assign w_sel_req = (r_sel == SEL_INC) ? bus.inc_req : bus.dec_req;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sel         <= SEL_INC;
      r_last_served <= SEL_DEC;
      r_count       <= '0;
      r_inc_ack     <= 1'b0;
      r_inc_nack    <= 1'b0;
      r_dec_ack     <= 1'b0;
      r_dec_nack    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.inc_req || bus.dec_req) begin
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
            if (bus.inc_req && bus.dec_req)
              r_sel <= (r_last_served == SEL_INC) ? SEL_DEC : SEL_INC;
            else if (bus.inc_req)
              r_sel <= SEL_INC;
            else
              r_sel <= SEL_DEC;
          end
        end

        S_EXEC: begin
          r_state       <= S_RELEASE;
          r_last_served <= r_sel;
          // Saturate at both ends: a refused request is nacked, count holds.
          if (r_sel == SEL_INC) begin
            if (r_count != MAX_C) begin
              r_count   <= r_count + ONE_C;
              r_inc_ack <= 1'b1;
            end else begin
              r_inc_nack <= 1'b1;
            end
          end else begin
            if (r_count != '0) begin
              r_count   <= r_count - ONE_C;
              r_dec_ack <= 1'b1;
            end else begin
              r_dec_nack <= 1'b1;
            end
          end
        end

        S_RELEASE: begin
          // Only the granted requester can end the transaction.
          if (!w_sel_req) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_inc_ack  <= 1'b0;
            r_inc_nack <= 1'b0;
            r_dec_ack  <= 1'b0;
            r_dec_nack <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inc_ack  = r_inc_ack;
  assign bus.inc_nack = r_inc_nack;
  assign bus.dec_ack  = r_dec_ack;
  assign bus.dec_nack = r_dec_nack;
  assign bus.count    = r_count;
  assign bus.busy     = r_busy;
  assign bus.full     = (r_count == MAX_C);
  assign bus.empty    = (r_count == '0);

endmodule

// File: tb/tb_occupancy_arbiter.sv
// Directed scoreboard bench for occupancy_arbiter: expected responses are
// queued when a request is raised and compared when the response appears.
module tb_occupancy_arbiter;

  localparam int WIDTH = 4;
  localparam int MAX   = 15;

  localparam logic [3:0] R_NONE     = 4'b0000;
  localparam logic [3:0] R_INC_ACK  = 4'b1000;
  localparam logic [3:0] R_INC_NACK = 4'b0100;
  localparam logic [3:0] R_DEC_ACK  = 4'b0010;
  localparam logic [3:0] R_DEC_NACK = 4'b0001;

  typedef struct {
    logic [3:0]       resp;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  occupancy_arbiter_if #(.WIDTH(WIDTH)) bus ();

  occupancy_arbiter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   model_count = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] resp_now();
    return {bus.inc_ack, bus.inc_nack, bus.dec_ack, bus.dec_nack};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: saturating counter, independent of the DUT's state machine.
  task automatic expect_op(input bit is_inc);
    exp_t e;
    if (is_inc) begin
      if (model_count != MAX) begin
        model_count++;
        e.resp = R_INC_ACK;
      end else begin
        e.resp = R_INC_NACK;
      end
    end else begin
      if (model_count != 0) begin
        model_count--;
        e.resp = R_DEC_ACK;
      end else begin
        e.resp = R_DEC_NACK;
      end
    end
    e.cnt = WIDTH'(model_count);
    sb.push_back(e);
  endtask

  task automatic await_resp(input string tag, input int exp_lat);
    int   n = 0;
    exp_t e;
    do begin
      tick();
      n++;
    end while (resp_now() == R_NONE && n < 20);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_resp"},  32'(resp_now()), 32'(e.resp));
      check({tag, "_count"}, 32'(bus.count),  32'(e.cnt));
      check({tag, "_full"},  32'(bus.full),   32'(e.cnt == WIDTH'(MAX)));
      check({tag, "_empty"}, 32'(bus.empty),  32'(e.cnt == '0));
    end
    if (exp_lat > 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic drop_req(input bit is_inc, input string tag);
    if (is_inc) bus.inc_req = 1'b0;
    else        bus.dec_req = 1'b0;
    tick();
    check({tag, "_resp_cleared"}, 32'(resp_now()), 32'(R_NONE));
    check({tag, "_idle"},         32'(bus.busy),   32'd0);
  endtask

  task automatic do_txn(input bit is_inc, input string tag);
    expect_op(is_inc);
    if (is_inc) bus.inc_req = 1'b1;
    else        bus.dec_req = 1'b1;
    await_resp(tag, 2);
    drop_req(is_inc, tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_empty"}, 32'(bus.empty), 32'd1);
    check({tag, "_full"},  32'(bus.full),  32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_resp"},  32'(resp_now()), 32'(R_NONE));
  endtask

  initial begin
    bus.inc_req = 1'b0;
    bus.dec_req = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Decrement at empty is refused.
    do_txn(1'b0, "underflow");

    // Single increment with latency and EXEC-cycle observation.
    expect_op(1'b1);
    bus.inc_req = 1'b1;
    tick();
    check("single_exec_busy", 32'(bus.busy),   32'd1);
    check("single_exec_resp", 32'(resp_now()), 32'(R_NONE));
    check("single_exec_cnt",  32'(bus.count),  32'd0);
    await_resp("single", 1);
    drop_req(1'b1, "single");

    // Fill to saturation, then one more increment is nacked.
    for (int i = 0; i < 14; i++) do_txn(1'b1, "fill");
    check("sat_full",  32'(bus.full),  32'd1);
    check("sat_count", 32'(bus.count), 32'd15);
    do_txn(1'b1, "overflow");
    check("overflow_hold", 32'(bus.count), 32'd15);

    // Fresh reset, then simultaneous requests alternate INC, DEC, INC.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_count = 0;
    check_reset_state("reset2");
    expect_op(1'b1);
    expect_op(1'b0);
    expect_op(1'b1);
    bus.inc_req = 1'b1;
    bus.dec_req = 1'b1;
    await_resp("rr1_inc", 2);
    drop_req(1'b1, "rr1");
    bus.inc_req = 1'b1;
    await_resp("rr2_dec", 2);
    drop_req(1'b0, "rr2");
    await_resp("rr3_inc", 2);
    drop_req(1'b1, "rr3");

    // Long hold: ack persists, pending dec is not served meanwhile.
    expect_op(1'b1);
    bus.inc_req = 1'b1;
    await_resp("hold", 2);
    bus.dec_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_resp",  32'(resp_now()), 32'(R_INC_ACK));
      check("hold_count", 32'(bus.count),  32'd2);
      check("hold_busy",  32'(bus.busy),   32'd1);
    end
    expect_op(1'b0);
    drop_req(1'b1, "hold");
    await_resp("hold_pending_dec", 2);
    drop_req(1'b0, "hold_dec");

    // Reach 7 and reset while the ack is held in RELEASE.
    for (int i = 0; i < 5; i++) do_txn(1'b1, "climb");
    expect_op(1'b1);
    bus.inc_req = 1'b1;
    await_resp("to_seven", 2);
    rst = 1'b1;
    tick();
    check_reset_state("mid_reset");
    rst = 1'b0;
    model_count = 0;
    // inc_req still high after reset is a new request.
    expect_op(1'b1);
    await_resp("post_reset_inc", 2);
    drop_req(1'b1, "post_reset");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
